// File: rtl/calc_pkg.sv
// Shared constants for the accumulator calculator: widths, internal ALU op
// codes and the push-button opcode decode.
package calc_pkg;

  localparam int DATA_W = 16;
  localparam int ALU_W  = 32;

  typedef logic [3:0] alu_op_t;

  // Internal ALU op codes are independent of the button encoding so the ALU
  // can be reused behind a different front end.
  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SLL = 4'b0011;
  localparam alu_op_t ALU_XOR = 4'b0100;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;
  localparam alu_op_t ALU_SRA = 4'b1000;

  function automatic alu_op_t decode_op(input logic [2:0] opcode);
    alu_op_t op;
    case (opcode)
      3'b000:  op = ALU_AND;
      3'b001:  op = ALU_OR;
      3'b010:  op = ALU_ADD;
      3'b011:  op = ALU_SUB;
      3'b100:  op = ALU_SLT;
      3'b101:  op = ALU_SLL;
      3'b110:  op = ALU_SRA;
      3'b111:  op = ALU_XOR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Purely combinational 32-bit ALU with a zero flag; shift amounts use only
// the low five bits of op2.
module calc_alu
  import calc_pkg::*;
(
  input  logic [ALU_W-1:0] op1,
  input  logic [ALU_W-1:0] op2,
  input  alu_op_t          op,
  output logic [ALU_W-1:0] result,
  output logic             zero
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_SLT: result = {{(ALU_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLL: result = op1 << shamt;
      ALU_SRA: result = $signed(op1) >>> shamt;
      ALU_XOR: result = op1 ^ op2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/calc_unit.sv
// Accumulator calculator: the LEDs show a 16-bit accumulator that, while the
// load button is held, takes the ALU result of (accumulator op switches).
module calc_unit
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              btnu,
  input  logic              btnd,
  input  logic              btnl,
  input  logic              btnc,
  input  logic              btnr,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led
);

  logic [DATA_W-1:0] acc;
  logic [ALU_W-1:0]  op1;
  logic [ALU_W-1:0]  op2;
  logic [ALU_W-1:0]  alu_result;
  logic              alu_zero;
  alu_op_t           alu_op;

  assign op1    = {{(ALU_W-DATA_W){acc[DATA_W-1]}}, acc};
  assign op2    = {{(ALU_W-DATA_W){sw[DATA_W-1]}}, sw};
  assign alu_op = decode_op({btnl, btnc, btnr});

  calc_alu u_alu (
    .op1    (op1),
    .op2    (op2),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Only the low half of the ALU result is kept; the rest wraps away.
  always_ff @(posedge clk or negedge btnu) begin
    if (!btnu)
      acc <= '0;
    else if (btnd)
      acc <= alu_result[DATA_W-1:0];
  end

  logic unused_alu_bits;
  assign unused_alu_bits = ^{alu_zero, alu_result[ALU_W-1:DATA_W]};

  assign led = acc;

endmodule

// File: tb/tb_calc_unit.sv
// Scoreboard bench for calc_unit: expected accumulator values are queued when
// a step is driven and compared once the clock edge has produced them.
module tb_calc_unit;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic        clk;
  logic        btnu;
  logic        btnd;
  logic        btnl;
  logic        btnc;
  logic        btnr;
  logic [15:0] sw;
  logic [15:0] led;

  int          checks;
  int          failures;
  logic [15:0] accModel;
  logic [15:0] expQueue[$];

  calc_unit dut (
    .clk  (clk),
    .btnu (btnu),
    .btnd (btnd),
    .btnl (btnl),
    .btnc (btnc),
    .btnr (btnr),
    .sw   (sw),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference computed on 16-bit values directly.
  function automatic logic [15:0] modelOp(input logic [2:0] opc,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (opc)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      OP_SLL:  return (sh >= 5'd16) ? 16'h0000 : (a << sh);
      OP_SRA:  return (sh >= 5'd16) ? {16{a[15]}} : 16'($signed(a) >>> sh);
      default: return a ^ b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: led=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] opc, input logic [15:0] swVal,
                               input logic en, input string tag);
    logic [15:0] expVal;
    @(negedge clk);
    {btnl, btnc, btnr} = opc;
    sw   = swVal;
    btnd = en;
    expVal = en ? modelOp(opc, accModel, swVal) : accModel;
    expQueue.push_back(expVal);
    accModel = expVal;
    @(posedge clk);
    #1;
    if (expQueue.size() == 0)
      checkOutput({tag, "_empty_queue"}, led, ~led);
    else
      checkOutput(tag, led, expQueue.pop_front());
  endtask

  task automatic runStep(input logic [2:0] opc, input logic [15:0] swVal,
                         input logic [15:0] tableExp, input string tag);
    applyStimulus(opc, swVal, 1'b1, tag);
    checkOutput({tag, "_table"}, led, tableExp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    accModel = 16'h0000;
    btnu = 1'b1;
    btnd = 1'b1;
    {btnl, btnc, btnr} = OP_ADD;
    sw = 16'h1234;

    // Reset with load requested and clock running
    #2 btnu = 1'b0;
    #1 checkOutput("reset_async", led, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_hold", led, 16'h0000);
    end
    @(negedge clk);
    btnu = 1'b1;
    btnd = 1'b0;
    accModel = 16'h0000;

    runStep(OP_ADD, 16'h354A, 16'h354A, "chain_add");
    runStep(OP_SUB, 16'h1234, 16'h2316, "chain_sub");
    runStep(OP_OR,  16'h1001, 16'h3317, "chain_or");
    runStep(OP_AND, 16'hF0F0, 16'h3010, "chain_and");
    runStep(OP_XOR, 16'h1FA2, 16'h2FB2, "chain_xor");
    runStep(OP_ADD, 16'h6AA2, 16'h9A54, "wrap_add");
    runStep(OP_SLL, 16'h0004, 16'hA540, "shift_sll");
    runStep(OP_SRA, 16'h0001, 16'hD2A0, "shift_sra");

    for (int i = 0; i < 5; i++)
      applyStimulus(3'(i + 3), 16'($urandom()), 1'b0, "hold");
    checkOutput("hold_table", led, 16'hD2A0);

    runStep(OP_SLT, 16'h46FF, 16'h0001, "slt_true");
    runStep(OP_SLT, 16'h8000, 16'h0000, "slt_false");

    runStep(OP_ADD, 16'h8001, 16'h8001, "pre_shift_load");
    runStep(OP_SLL, 16'h0010, 16'h0000, "sll_16");
    runStep(OP_ADD, 16'h8001, 16'h8001, "pre_sra_load");
    runStep(OP_SRA, 16'h001F, 16'hFFFF, "sra_31");

    for (int i = 0; i < 40; i++)
      applyStimulus(3'($urandom_range(0, 7)), 16'($urandom()),
                    1'($urandom_range(0, 3) != 0), "random");

    runStep(OP_OR, 16'h0055, accModel | 16'h0055, "pre_reset_load");

    // Reset pulled between edges must clear before the next edge
    @(negedge clk);
    {btnl, btnc, btnr} = OP_ADD;
    sw   = 16'h1111;
    btnd = 1'b1;
    #2 btnu = 1'b0;
    #1 checkOutput("midrun_reset_async", led, 16'h0000);
    @(posedge clk);
    #1 checkOutput("midrun_reset_edge", led, 16'h0000);
    @(negedge clk);
    btnu = 1'b1;
    btnd = 1'b0;
    accModel = 16'h0000;

    runStep(OP_ADD, 16'hFFFF, 16'hFFFF, "post_reset_add");
    runStep(OP_ADD, 16'h0001, 16'h0000, "post_reset_wrap");

    if (expQueue.size() != 0)
      checkOutput("queue_drained", 16'(expQueue.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
